// File: rtl/id_ex_if.sv
// Decode/execute boundary bundle: decode payload and handshake in, EX register contents out.
interface id_ex_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic [DATA_W-1:0] id_rs_value;
  logic [DATA_W-1:0] id_rt_value;
  logic [DATA_W-1:0] id_imm;
  logic [5:0]        id_alu_op;
  logic              id_wb_en;
  logic [ADDR_W-1:0] id_wb_addr;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_rs_value;
  logic [DATA_W-1:0] ex_rt_value;
  logic [DATA_W-1:0] ex_imm;
  logic [5:0]        ex_alu_op;
  logic [ADDR_W-1:0] ex_wb_addr;
  logic              ex_wb_en;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_fwd_en;
  logic              load_use_stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_value, id_rt_value, id_imm,
           id_alu_op, id_wb_en, id_wb_addr, id_mem_read, id_mem_write, flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rs_value, ex_rt_value, ex_imm, ex_alu_op,
           ex_wb_addr, ex_wb_en, ex_mem_read, ex_mem_write, ex_fwd_en, load_use_stall,
           stall_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_value, id_rt_value, id_imm,
           id_alu_op, id_wb_en, id_wb_addr, id_mem_read, id_mem_write, flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rs_value, ex_rt_value, ex_imm, ex_alu_op,
           ex_wb_addr, ex_wb_en, ex_mem_read, ex_mem_write, ex_fwd_en, load_use_stall,
           stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, execute back-pressure, flush and a
// saturating interlock-cycle counter.
module id_ex_stage #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_pc;
  logic [DATA_W-1:0] r_ex_rs_value;
  logic [DATA_W-1:0] r_ex_rt_value;
  logic [DATA_W-1:0] r_ex_imm;
  logic [5:0]        r_ex_alu_op;
  logic [ADDR_W-1:0] r_ex_wb_addr;
  logic              r_ex_wb_en;
  logic              r_ex_mem_read;
  logic              r_ex_mem_write;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_hazard;
  logic w_load_use_stall;
  logic w_id_ready;
  logic w_accept;
  logic w_cnt_sat;

  // Load data only exists after MEM, so an EX load cannot feed the decode bypass.
  assign w_hazard = bus.id_valid & r_ex_valid & r_ex_mem_read & r_ex_wb_en &
                    (r_ex_wb_addr != '0) &
                    ((r_ex_wb_addr == bus.id_rs_addr) | (r_ex_wb_addr == bus.id_rt_addr));

  assign w_load_use_stall = w_hazard & ~bus.flush;
  assign w_id_ready       = ~bus.flush & ~w_hazard & (~r_ex_valid | bus.ex_ready);
  assign w_accept         = bus.id_valid & w_id_ready;
  assign w_cnt_sat        = (r_stall_count == {CNT_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_rs_value  <= '0;
      r_ex_rt_value  <= '0;
      r_ex_imm       <= '0;
      r_ex_alu_op    <= '0;
      r_ex_wb_addr   <= '0;
      r_ex_wb_en     <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_stall_count  <= '0;
    end else begin
      if (bus.flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_accept) begin
        r_ex_valid     <= 1'b1;
        r_ex_pc        <= bus.id_pc;
        r_ex_rs_value  <= bus.id_rs_value;
        r_ex_rt_value  <= bus.id_rt_value;
        r_ex_imm       <= bus.id_imm;
        r_ex_alu_op    <= bus.id_alu_op;
        r_ex_wb_addr   <= bus.id_wb_addr;
        r_ex_wb_en     <= bus.id_wb_en;
        r_ex_mem_read  <= bus.id_mem_read;
        r_ex_mem_write <= bus.id_mem_write;
      end else if (r_ex_valid & bus.ex_ready) begin
        // Drain without refill: during a hazard this is the bubble.
        r_ex_valid <= 1'b0;
      end

      if (w_load_use_stall && !w_cnt_sat) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign bus.id_ready       = w_id_ready;
  assign bus.load_use_stall = w_load_use_stall;
  assign bus.ex_fwd_en      = r_ex_valid & r_ex_wb_en & ~r_ex_mem_read;
  assign bus.ex_valid       = r_ex_valid;
  assign bus.ex_pc          = r_ex_pc;
  assign bus.ex_rs_value    = r_ex_rs_value;
  assign bus.ex_rt_value    = r_ex_rt_value;
  assign bus.ex_imm         = r_ex_imm;
  assign bus.ex_alu_op      = r_ex_alu_op;
  assign bus.ex_wb_addr     = r_ex_wb_addr;
  assign bus.ex_wb_en       = r_ex_wb_en;
  assign bus.ex_mem_read    = r_ex_mem_read;
  assign bus.ex_mem_write   = r_ex_mem_write;
  assign bus.stall_count    = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, all checked every cycle
// against a behavioural model; a second instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  id_ex_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) bus ();
  id_ex_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2))  bus2 ();

  id_ex_stage #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_ex_stage #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.id_valid     = bus.id_valid;
  assign bus2.id_pc        = bus.id_pc;
  assign bus2.id_rs_addr   = bus.id_rs_addr;
  assign bus2.id_rt_addr   = bus.id_rt_addr;
  assign bus2.id_rs_value  = bus.id_rs_value;
  assign bus2.id_rt_value  = bus.id_rt_value;
  assign bus2.id_imm       = bus.id_imm;
  assign bus2.id_alu_op    = bus.id_alu_op;
  assign bus2.id_wb_en     = bus.id_wb_en;
  assign bus2.id_wb_addr   = bus.id_wb_addr;
  assign bus2.id_mem_read  = bus.id_mem_read;
  assign bus2.id_mem_write = bus.id_mem_write;
  assign bus2.flush        = bus.flush;
  assign bus2.ex_ready     = bus.ex_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: what the EX slot holds and how many interlock cycles have occurred.
  typedef struct {
    bit              valid;
    logic [DW-1:0]   pc, rsv, rtv, imm;
    logic [5:0]      op;
    logic [AW-1:0]   wa;
    bit              we, mr, mw;
  } ex_slot_t;

  ex_slot_t m;
  int       m_cnt;

  initial begin
    bit exp_haz, exp_stall, exp_rdy, exp_fwd;
    int sat16, sat2;
    forever begin
      @(negedge clk);
      if (rst) begin
        m = '{default: '0};
        m_cnt = 0;
      end
      exp_haz = bus.id_valid && m.valid && m.mr && m.we && (m.wa != 0) &&
                (m.wa == bus.id_rs_addr || m.wa == bus.id_rt_addr);
      exp_stall = exp_haz && !bus.flush;
      exp_rdy   = !bus.flush && !exp_haz && (!m.valid || bus.ex_ready);
      exp_fwd   = m.valid && m.we && !m.mr;
      sat16 = (m_cnt > 65535) ? 65535 : m_cnt;
      sat2  = (m_cnt > 3) ? 3 : m_cnt;

      chk("id_ready", bus.id_ready, exp_rdy);
      chk("load_use_stall", bus.load_use_stall, exp_stall);
      chk("ex_fwd_en", bus.ex_fwd_en, exp_fwd);
      chk("ex_valid", bus.ex_valid, m.valid);
      chk("ex_pc", bus.ex_pc, m.pc);
      chk("ex_rs_value", bus.ex_rs_value, m.rsv);
      chk("ex_rt_value", bus.ex_rt_value, m.rtv);
      chk("ex_imm", bus.ex_imm, m.imm);
      chk("ex_alu_op", bus.ex_alu_op, m.op);
      chk("ex_wb_addr", bus.ex_wb_addr, m.wa);
      chk("ex_ctl", {bus.ex_wb_en, bus.ex_mem_read, bus.ex_mem_write}, {m.we, m.mr, m.mw});
      chk("stall_count", bus.stall_count, sat16);
      chk("small.stall_count", bus2.stall_count, sat2);
      chk("small.ex_valid", bus2.ex_valid, m.valid);
      chk("small.id_ready", bus2.id_ready, exp_rdy);

      if (!rst) begin
        if (bus.flush) begin
          m.valid = 0;
        end else if (bus.id_valid && exp_rdy) begin
          m = '{valid: 1, pc: bus.id_pc, rsv: bus.id_rs_value, rtv: bus.id_rt_value,
                imm: bus.id_imm, op: bus.id_alu_op, wa: bus.id_wb_addr, we: bus.id_wb_en,
                mr: bus.id_mem_read, mw: bus.id_mem_write};
        end else if (m.valid && bus.ex_ready) begin
          m.valid = 0;
        end
        if (exp_stall) m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input bit v, input logic [DW-1:0] pc, input logic [AW-1:0] rsa,
                        input logic [AW-1:0] rta, input logic [DW-1:0] rsv, input bit we,
                        input logic [AW-1:0] wa, input bit mr);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs_addr   = rsa;
    bus.id_rt_addr   = rta;
    bus.id_rs_value  = rsv;
    bus.id_rt_value  = pc ^ 32'hA5A5_0000;
    bus.id_imm       = pc + 32'h10;
    bus.id_alu_op    = pc[7:2];
    bus.id_wb_en     = we;
    bus.id_wb_addr   = wa;
    bus.id_mem_read  = mr;
    bus.id_mem_write = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.id_valid     = ($urandom_range(0, 9) < 8);
    bus.id_pc        = $urandom;
    bus.id_rs_addr   = AW'($urandom_range(0, 3));
    bus.id_rt_addr   = AW'($urandom_range(0, 3));
    bus.id_rs_value  = $urandom;
    bus.id_rt_value  = $urandom;
    bus.id_imm       = $urandom;
    bus.id_alu_op    = 6'($urandom);
    bus.id_wb_en     = ($urandom_range(0, 3) != 0);
    bus.id_wb_addr   = AW'($urandom_range(0, 3));
    bus.id_mem_read  = ($urandom_range(0, 1) == 1);
    bus.id_mem_write = ($urandom_range(0, 3) == 0);
    bus.flush        = ($urandom_range(0, 9) == 0);
    bus.ex_ready     = ($urandom_range(0, 9) < 7);
  endtask

  logic [DW-1:0] held_pc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_id(0, '0, '0, '0, '0, 0, '0, 0);
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b0;
    tick();
    tick();
    chk("rst.ex_valid", bus.ex_valid, 1'b0);
    chk("rst.ex_pc", bus.ex_pc, 32'h0);
    chk("rst.stall_count", bus.stall_count, 16'h0);
    chk("rst.load_use_stall", bus.load_use_stall, 1'b0);
    rst = 1'b0;

    // First transfer and back-to-back stream
    bus.ex_ready = 1'b1;
    set_id(1, 32'h1000, 6'd1, 6'd2, 32'h5, 0, 6'd0, 0);
    settle();
    chk("b2b.id_ready0", bus.id_ready, 1'b1);
    tick();
    chk("first.ex_valid", bus.ex_valid, 1'b1);
    chk("first.ex_pc", bus.ex_pc, 32'h1000);
    chk("first.ex_rs_value", bus.ex_rs_value, 32'h5);
    set_id(1, 32'h1004, 6'd1, 6'd2, 32'h6, 0, 6'd0, 0);
    settle();
    chk("b2b.id_ready1", bus.id_ready, 1'b1);
    tick();
    chk("b2b.ex_pc1", bus.ex_pc, 32'h1004);
    set_id(1, 32'h1008, 6'd1, 6'd2, 32'h7, 0, 6'd0, 0);
    settle();
    chk("b2b.id_ready2", bus.id_ready, 1'b1);
    tick();
    chk("b2b.ex_pc2", bus.ex_pc, 32'h1008);

    // Load-use interlock on rs
    set_id(1, 32'h2000, 6'd1, 6'd2, 32'h0, 1, 6'd8, 1);
    tick();
    set_id(1, 32'h2004, 6'd8, 6'd3, 32'h9, 0, 6'd0, 0);
    settle();
    chk("lu.stall", bus.load_use_stall, 1'b1);
    chk("lu.id_ready", bus.id_ready, 1'b0);
    chk("lu.fwd", bus.ex_fwd_en, 1'b0);
    tick();
    chk("lu.bubble", bus.ex_valid, 1'b0);
    chk("lu.count", bus.stall_count, 16'd1);
    tick();
    chk("lu.enter_valid", bus.ex_valid, 1'b1);
    chk("lu.enter_pc", bus.ex_pc, 32'h2004);

    // Load into $0 never interlocks; ALU result is forwardable
    set_id(1, 32'h3000, 6'd1, 6'd2, 32'h0, 1, 6'd0, 1);
    tick();
    set_id(1, 32'h3004, 6'd0, 6'd0, 32'h0, 1, 6'd8, 0);
    settle();
    chk("zero.stall", bus.load_use_stall, 1'b0);
    chk("zero.id_ready", bus.id_ready, 1'b1);
    tick();
    chk("alu.fwd", bus.ex_fwd_en, 1'b1);
    set_id(1, 32'h3008, 6'd8, 6'd1, 32'h0, 0, 6'd0, 0);
    settle();
    chk("alu.stall", bus.load_use_stall, 1'b0);
    tick();

    // Back-pressure from execute
    bus.ex_ready = 1'b0;
    set_id(1, 32'h4000, 6'd1, 6'd2, 32'h0, 0, 6'd0, 0);
    settle();
    chk("bp.id_ready", bus.id_ready, 1'b0);
    held_pc = bus.ex_pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp.held_pc", bus.ex_pc, held_pc);
      chk("bp.held_valid", bus.ex_valid, 1'b1);
    end
    bus.ex_ready = 1'b1;
    settle();
    chk("bp.release_ready", bus.id_ready, 1'b1);
    tick();
    chk("bp.release_pc", bus.ex_pc, 32'h4000);

    // Flush kills both EX and the incoming instruction
    set_id(1, 32'h5000, 6'd1, 6'd2, 32'h0, 0, 6'd0, 0);
    bus.flush = 1'b1;
    settle();
    chk("flush.id_ready", bus.id_ready, 1'b0);
    tick();
    chk("flush.ex_valid", bus.ex_valid, 1'b0);
    bus.flush = 1'b0;

    // Hazard held by back-pressure: 5 stall cycles saturate the 2-bit counter
    set_id(1, 32'h6000, 6'd1, 6'd2, 32'h0, 1, 6'd9, 1);
    tick();
    bus.ex_ready = 1'b0;
    set_id(1, 32'h6004, 6'd1, 6'd9, 32'h0, 0, 6'd0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("sat.count16", bus.stall_count, 16'd6);
    chk("sat.count2", bus2.stall_count, 2'd3);
    bus.ex_ready = 1'b1;
    tick();
    tick();
    chk("sat.enter_pc", bus.ex_pc, 32'h6004);

    // Random traffic with one asynchronous reset mid-run
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if (i == 1500) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
